qspi_stream_fifo: RTL and testbench
===================================

QSPI_STREAM_FIFO -- requirements
Module: qspi_stream_fifo

Interface
REQ-001 SHALL have parameter DEPTH_NIB, default 16, storage capacity in nibbles; power of two, at least 4.
REQ-002 SHALL have parameter POP_W, default 2, pop width in bits; legal values 1, 2 or 4.
REQ-003 SHALL have parameter WORD_NIB, default 8, width of the word buffer in nibbles.
REQ-004 SHALL derive local constants: CAP = DEPTH_NIB*4 bits; CW = clog2(CAP)+1.
REQ-005 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n, input, 1; reset is synchronous and active-low.
REQ-007 SHALL have port clear, input, 1, flush request from the arbiter.
REQ-008 SHALL have port push, input, 1, sampler data strobe.
REQ-009 SHALL have port push_data, input, 4, sampled nibble; bit 3 is the oldest bit on the wire.
REQ-010 SHALL have port pop, input, 1, consumer request for the next POP_W bits.
REQ-011 SHALL have port pop_data, output, POP_W, the oldest stored bits; MSB is the oldest.
REQ-012 SHALL have port empty, output, 1, high when count < POP_W.
REQ-013 SHALL have port full, output, 1, high when count > CAP-4.
REQ-014 SHALL have port count, output, CW, the number of stored bits.
REQ-015 SHALL have port level, input, CW, the watermark threshold in bits.
REQ-016 SHALL have port at_level, output, 1, high when count >= level.
REQ-017 SHALL have port buffer, output, WORD_NIB*4, the last pushed nibbles; the newest nibble is in bits [3:0].
REQ-018 SHALL have ports overflow and underflow, output, 1 each, sticky error flags.

Function
REQ-019 SHALL store bits in a circular array of CAP bits, using bit-granular write and read pointers that wrap modulo CAP.
REQ-020 SHALL accept a push when push=1, full=0 and clear=0; the 4 bits are written oldest-first at the write pointer, and the pointer advances by 4.
REQ-021 SHALL accept a pop when pop=1, empty=0 and clear=0; the read pointer advances by POP_W.
REQ-022 SHALL evaluate push and pop acceptance from the pre-edge count; a simultaneous accepted push and pop updates count by +4-POP_W.
REQ-023 SHALL NOT bypass: a pop while empty is rejected even if a push occurs in the same cycle.
REQ-024 SHALL drive pop_data combinationally from the bits at the read pointer when empty=0, and drive 0 when empty=1.
REQ-025 SHALL make a pushed nibble visible on pop_data the cycle after its push edge, giving 1-cycle latency.
REQ-026 SHALL handle a push while full (clear=0) as follows: drop the data, leave pointers and count unchanged, and set overflow.
REQ-027 SHALL handle a pop while empty (clear=0) as follows: leave state unchanged and set underflow.
REQ-028 SHALL shift buffer left by 4 and load push_data into bits [3:0] on every push=1 with clear=0, including dropped pushes.
REQ-029 SHALL give clear priority over push and pop: the pointers, count, buffer, overflow and underflow all go to 0, and that cycle's push and pop are ignored with no flags set.
REQ-030 SHALL handle pointer wrap-around transparently; the data order is preserved across the CAP boundary.
REQ-031 SHALL keep count within [0, CAP] at all times.
REQ-032 SHALL derive empty, full, at_level and count directly from the registered count, with no added latency.

Reset
REQ-033 SHALL, when rst_n=0 at a rising edge, set the pointers, count, buffer, overflow and underflow to 0 and ignore all other inputs.
REQ-034 SHALL, after reset, present empty=1, full=0, pop_data=0, count=0, and at_level=(level==0).
REQ-035 SHALL treat a reset asserted mid-stream identically to REQ-033; no stored data survives.

Verification
REQ-036 SHALL cover basic order (defaults): push 0xA then 0x5, then pop 4 times -> pop_data 2'b10,2'b10,2'b01,2'b01; count goes 8,6,4,2,0; then empty=1.
REQ-037 SHALL cover fill and overflow: 16 pushes -> count=64, full=1; a 17th push of 0xF -> count stays 64, overflow=1, and buffer bits [3:0] are 0xF.
REQ-038 SHALL cover underflow and no bypass: with the FIFO empty, apply pop with push 0x3 in the same cycle -> underflow=1, count=4; the next-cycle pop_data is 2'b00.
REQ-039 SHALL cover wrap-around: interleave 40 pushes of an incrementing nibble with 80 pops -> popped stream equals the pushed stream, with no error flags.
REQ-040 SHALL cover clear priority: at count=20, assert clear with push and pop -> count=0, buffer=0, flags 0, empty=1.
REQ-041 SHALL cover watermark and POP_W=4: with level=12, 3 pushes -> at_level=1; 1 pop -> count=8, at_level=0.

Source files
------------

// File: rtl/qspi_stream_fifo.sv
// qspi_stream_fifo
// Bit-granular stream FIFO between the QSPI sampler and its consumer.
// Nibbles are written four bits at a time (oldest bit first) into a circular
// bit array; the consumer drains POP_W bits per pop. A shift register keeps
// the most recent nibbles for inspection, and sticky flags record pushes that
// hit a full FIFO and pops that hit an empty one.
module qspi_stream_fifo #(
  parameter  int DEPTH_NIB = 16,
  parameter  int POP_W     = 2,
  parameter  int WORD_NIB  = 8,
  localparam int CAP       = DEPTH_NIB * 4,
  localparam int CW        = $clog2(CAP) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  push,
  input  logic [3:0]            push_data,
  input  logic                  pop,
  output logic [POP_W-1:0]      pop_data,
  output logic                  empty,
  output logic                  full,
  output logic [CW-1:0]         count,
  input  logic [CW-1:0]         level,
  output logic                  at_level,
  output logic [WORD_NIB*4-1:0] buffer,
  output logic                  overflow,
  output logic                  underflow
);

  // Pointer width: CAP is a power of two, so plain PW-bit arithmetic wraps
  // modulo CAP for free.
  localparam int PW = $clog2(CAP);
  localparam int BW = WORD_NIB * 4;

  localparam logic [CW-1:0] LP_POP_W  = CW'(POP_W);
  localparam logic [CW-1:0] LP_NIB    = CW'(4);
  localparam logic [CW-1:0] LP_CAP_M4 = CW'(CAP - 4);

  logic [CAP-1:0] r_mem;
  logic [PW-1:0]  r_wptr;
  logic [PW-1:0]  r_rptr;
  logic [CW-1:0]  r_count;
  logic [BW-1:0]  r_buffer;
  logic           r_overflow;
  logic           r_underflow;

  logic           w_empty;
  logic           w_full;
  logic           w_pushOk;
  logic           w_popOk;
  logic [CW-1:0]  w_addBits;
  logic [CW-1:0]  w_subBits;
  logic [PW-1:0]  w_waddr [4];
  logic [PW-1:0]  w_raddr [POP_W];

  assign w_empty   = (r_count < LP_POP_W);
  assign w_full    = (r_count > LP_CAP_M4);
  // Acceptance uses the pre-edge count, so a pop on an empty FIFO is refused
  // even when a push lands in the same cycle.
  assign w_pushOk  = push & ~w_full  & ~clear;
  assign w_popOk   = pop  & ~w_empty & ~clear;
  assign w_addBits = w_pushOk ? LP_NIB   : '0;
  assign w_subBits = w_popOk  ? LP_POP_W : '0;

  // Bit addresses touched by a push and presented to the reader, wrapping at CAP.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_waddr[i] = r_wptr + PW'(i);
    end
    for (int i = 0; i < POP_W; i++) begin
      w_raddr[i] = r_rptr + PW'(i);
    end
  end

  // Storage array: write the nibble MSB (oldest wire bit) first at the write pointer.
  always_ff @(posedge clk) begin
    if (rst_n && w_pushOk) begin
      for (int i = 0; i < 4; i++) begin
        r_mem[w_waddr[i]] <= push_data[2'(3 - i)];
      end
    end
  end

  // Pointers, count, word buffer and sticky flags; clear behaves like reset.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_buffer    <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (push) begin
        r_buffer <= (r_buffer << 4) | BW'(push_data);
      end
      if (push && w_full) begin
        r_overflow <= 1'b1;
      end
      if (pop && w_empty) begin
        r_underflow <= 1'b1;
      end
      if (w_pushOk) begin
        r_wptr <= r_wptr + PW'(4);
      end
      if (w_popOk) begin
        r_rptr <= r_rptr + PW'(POP_W);
      end
      r_count <= r_count + w_addBits - w_subBits;
    end
  end

  // Oldest POP_W bits at the read pointer, oldest in the MSB; zero when empty.
  always_comb begin
    pop_data = '0;
    if (!w_empty) begin
      for (int i = 0; i < POP_W; i++) begin
        pop_data[POP_W-1-i] = r_mem[w_raddr[i]];
      end
    end
  end

  assign empty     = w_empty;
  assign full      = w_full;
  assign count     = r_count;
  assign at_level  = (r_count >= level);
  assign buffer    = r_buffer;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

endmodule

// File: tb/tb_qspi_stream_fifo.sv
// tb_qspi_stream_fifo
// Directed and randomized stimulus for qspi_stream_fifo. A bit queue holds the
// expected FIFO contents; every step compares all outputs against it. A second
// instance with POP_W=4 covers the nibble-wide pop and watermark case.
module tb_qspi_stream_fifo;

  localparam int CAP  = 64;
  localparam int CW   = 7;
  localparam int POPW = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           clear, push, pop;
  logic [3:0]     push_data;
  logic [CW-1:0]  level;
  logic [1:0]     pop_data;
  logic           empty, full, at_level, overflow, underflow;
  logic [CW-1:0]  count;
  logic [31:0]    buffer;

  logic           clear4, push4, pop4;
  logic [3:0]     push_data4;
  logic [CW-1:0]  level4;
  logic [3:0]     pop_data4;
  logic           empty4, full4, at_level4, overflow4, underflow4;
  logic [CW-1:0]  count4;
  logic [31:0]    buffer4;

  int total = 0;
  int bad   = 0;

  bit          mq[$];
  logic [31:0] mbuf;
  logic        movf, munf;

  always #5 clk = ~clk;

  qspi_stream_fifo dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .push(push), .push_data(push_data),
    .pop(pop), .pop_data(pop_data), .empty(empty), .full(full), .count(count),
    .level(level), .at_level(at_level), .buffer(buffer),
    .overflow(overflow), .underflow(underflow)
  );

  qspi_stream_fifo #(.POP_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .clear(clear4), .push(push4), .push_data(push_data4),
    .pop(pop4), .pop_data(pop_data4), .empty(empty4), .full(full4), .count(count4),
    .level(level4), .at_level(at_level4), .buffer(buffer4),
    .overflow(overflow4), .underflow(underflow4)
  );

  // One comparison: count it, and report tag/observed/expected on failure.
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every output of the main instance with the queue model.
  task automatic checkOutput();
    logic [1:0] ePd;
    ePd = 2'b00;
    if (mq.size() >= POPW) ePd = {mq[0], mq[1]};
    chk("count",     64'(count),     64'(mq.size()));
    chk("empty",     64'(empty),     64'(mq.size() < POPW));
    chk("full",      64'(full),      64'(mq.size() > CAP - 4));
    chk("at_level",  64'(at_level),  64'(mq.size() >= int'(level)));
    chk("pop_data",  64'(pop_data),  64'(ePd));
    chk("buffer",    64'(buffer),    64'(mbuf));
    chk("overflow",  64'(overflow),  64'(movf));
    chk("underflow", 64'(underflow), 64'(munf));
  endtask

  // Drive one cycle on the main instance, advance the model from the pre-edge
  // state, then check all outputs shortly after the edge.
  task automatic applyStimulus(input bit p, input logic [3:0] d, input bit po, input bit c);
    bit pushOk, popOk;
    push = p; push_data = d; pop = po; clear = c;
    if (!rst_n || c) begin
      mq.delete();
      mbuf = '0; movf = 1'b0; munf = 1'b0;
    end else begin
      pushOk = p  && (mq.size() <= CAP - 4);
      popOk  = po && (mq.size() >= POPW);
      if (p) mbuf = {mbuf[27:0], d};
      if (p && !pushOk) movf = 1'b1;
      if (po && !popOk) munf = 1'b1;
      if (popOk) repeat (POPW) void'(mq.pop_front());
      if (pushOk) for (int i = 3; i >= 0; i--) mq.push_back(d[i]);
    end
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    rst_n = 1'b0; clear = 0; push = 0; pop = 0; push_data = 0; level = 0;
    clear4 = 0; push4 = 0; pop4 = 0; push_data4 = 0; level4 = 7'd12;
    mbuf = '0; movf = 0; munf = 0;

    // Reset state
    applyStimulus(1, 4'h9, 1, 0);
    applyStimulus(0, 4'h0, 0, 0);
    chk("rst_empty",    64'(empty),    64'd1);
    chk("rst_pop_data", 64'(pop_data), 64'd0);
    chk("rst_at_level", 64'(at_level), 64'd1);
    rst_n = 1'b1;

    // Basic order: A then 5, four pops
    applyStimulus(1, 4'hA, 0, 0);
    applyStimulus(1, 4'h5, 0, 0);
    chk("order_cnt8", 64'(count), 64'd8);
    chk("order_pd0",  64'(pop_data), 64'b10);
    applyStimulus(0, 0, 1, 0);
    chk("order_cnt6", 64'(count), 64'd6);
    chk("order_pd1",  64'(pop_data), 64'b10);
    applyStimulus(0, 0, 1, 0);
    chk("order_cnt4", 64'(count), 64'd4);
    chk("order_pd2",  64'(pop_data), 64'b01);
    applyStimulus(0, 0, 1, 0);
    chk("order_cnt2", 64'(count), 64'd2);
    chk("order_pd3",  64'(pop_data), 64'b01);
    applyStimulus(0, 0, 1, 0);
    chk("order_cnt0", 64'(count), 64'd0);
    chk("order_empty", 64'(empty), 64'd1);

    // Fill to capacity, then one push too many
    for (int i = 0; i < 16; i++) applyStimulus(1, 4'($urandom), 0, 0);
    chk("fill_cnt",  64'(count), 64'd64);
    chk("fill_full", 64'(full),  64'd1);
    applyStimulus(1, 4'hF, 0, 0);
    chk("ovf_cnt",  64'(count), 64'd64);
    chk("ovf_flag", 64'(overflow), 64'd1);
    chk("ovf_buf",  64'(buffer[3:0]), 64'hF);
    applyStimulus(0, 0, 0, 1);

    // Underflow with a simultaneous push: no bypass
    applyStimulus(1, 4'h3, 1, 0);
    chk("unf_flag", 64'(underflow), 64'd1);
    chk("unf_cnt",  64'(count), 64'd4);
    chk("unf_pd",   64'(pop_data), 64'b00);
    applyStimulus(0, 0, 0, 1);

    // Wrap-around: 40 nibbles streamed through 80 pops
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1, 4'(i), 0, 0);
      applyStimulus(0, 0, 1, 0);
      applyStimulus(0, 0, 1, 0);
    end
    chk("wrap_cnt", 64'(count), 64'd0);
    chk("wrap_ovf", 64'(overflow), 64'd0);
    chk("wrap_unf", 64'(underflow), 64'd0);

    // Clear priority over push and pop, with a flag already set
    applyStimulus(0, 0, 1, 0);
    for (int i = 0; i < 5; i++) applyStimulus(1, 4'($urandom), 0, 0);
    chk("clr_pre_cnt", 64'(count), 64'd20);
    applyStimulus(1, 4'hF, 1, 1);
    chk("clr_cnt",   64'(count), 64'd0);
    chk("clr_buf",   64'(buffer), 64'd0);
    chk("clr_unf",   64'(underflow), 64'd0);
    chk("clr_ovf",   64'(overflow), 64'd0);
    chk("clr_empty", 64'(empty), 64'd1);

    // Randomized traffic: fill-biased half, drain-biased half, rare clears
    for (int i = 0; i < 600; i++) begin
      level = 7'($urandom_range(0, 70));
      applyStimulus((i < 300) ? ($urandom % 4 != 0) : ($urandom % 4 == 0),
                    4'($urandom),
                    (i < 300) ? ($urandom % 4 == 0) : ($urandom % 4 != 0),
                    ($urandom % 50 == 0));
    end

    // Mid-stream reset discards everything
    for (int i = 0; i < 6; i++) applyStimulus(1, 4'($urandom), 0, 0);
    level = 7'd0;
    rst_n = 1'b0;
    applyStimulus(1, 4'h5, 1, 0);
    rst_n = 1'b1;
    chk("mrst_cnt",      64'(count), 64'd0);
    chk("mrst_pd",       64'(pop_data), 64'd0);
    chk("mrst_at_level", 64'(at_level), 64'd1);

    // POP_W=4 instance: watermark at 12 bits
    push4 = 1; push_data4 = 4'h9; @(posedge clk); #1;
    push_data4 = 4'h6; @(posedge clk); #1;
    push_data4 = 4'hC; @(posedge clk); #1;
    push4 = 0;
    chk("p4_cnt12",  64'(count4), 64'd12);
    chk("p4_atlvl1", 64'(at_level4), 64'd1);
    chk("p4_pd0",    64'(pop_data4), 64'h9);
    pop4 = 1; @(posedge clk); #1;
    pop4 = 0;
    chk("p4_cnt8",   64'(count4), 64'd8);
    chk("p4_atlvl0", 64'(at_level4), 64'd0);
    chk("p4_pd1",    64'(pop_data4), 64'h6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
